// File: rtl/vga_if.sv
// vga_if: raster bus between the timing generator and the draw stages.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered raster counters, sync/blank decode and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter int SYNC_POS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   vga_if.out          vga_out,
   output logic        frame_start,
   output logic        line_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_BLNK   = 11'(H_ACTIVE);
   localparam logic [10:0] V_BLNK   = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        SYNC_ACT = (SYNC_POS != 0);

   // Counters are 11 bits wide, so larger rasters would silently alias.
   if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
   end

   logic [10:0] hcount_reg, hcount_next;
   logic [10:0] vcount_reg, vcount_next;
   logic        hsync_reg, hsync_next;
   logic        vsync_reg, vsync_next;
   logic        hblnk_reg, hblnk_next;
   logic        vblnk_reg, vblnk_next;
   logic        line_start_reg, line_start_next;
   logic        frame_start_reg, frame_start_next;

   always_comb begin
      hcount_next = hcount_reg + 11'd1;
      vcount_next = vcount_reg;
      if (hcount_reg == H_LAST) begin
         hcount_next = 11'd0;
         vcount_next = (vcount_reg == V_LAST) ? 11'd0 : vcount_reg + 11'd1;
      end
   end

   // Flags decode the next position so they land in the same cycle as the counters.
   always_comb begin
      hblnk_next       = (hcount_next >= H_BLNK);
      vblnk_next       = (vcount_next >= V_BLNK);
      hsync_next       = ((hcount_next >= HS_BEG) && (hcount_next < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      vsync_next       = ((vcount_next >= VS_BEG) && (vcount_next < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      line_start_next  = (hcount_next == 11'd0);
      frame_start_next = (hcount_next == 11'd0) && (vcount_next == 11'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_reg      <= 11'd0;
         vcount_reg      <= 11'd0;
         hsync_reg       <= ~SYNC_ACT;
         vsync_reg       <= ~SYNC_ACT;
         hblnk_reg       <= 1'b0;
         vblnk_reg       <= 1'b0;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else if (en) begin
         hcount_reg      <= hcount_next;
         vcount_reg      <= vcount_next;
         hsync_reg       <= hsync_next;
         vsync_reg       <= vsync_next;
         hblnk_reg       <= hblnk_next;
         vblnk_reg       <= vblnk_next;
         line_start_reg  <= line_start_next;
         frame_start_reg <= frame_start_next;
      end else begin
         // Strobes only fire on edges that advance, so a stall never repeats them.
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_reg <= 16'd0;
      end else if (en && frame_start_next) begin
         frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_reg;
`endif

   assign vga_out.hcount = hcount_reg;
   assign vga_out.vcount = vcount_reg;
   assign vga_out.hsync  = hsync_reg;
   assign vga_out.vsync  = vsync_reg;
   assign vga_out.hblnk  = hblnk_reg;
   assign vga_out.vblnk  = vblnk_reg;
   assign vga_out.rgb    = 12'h000;
   assign line_start     = line_start_reg;
   assign frame_start    = frame_start_reg;

endmodule
